otter_fetch_stage: RTL and testbench

Instruction fetch stage for the OTTER pipeline. It owns the PC and issues requests on the instruction-memory port. It buffers returned words in a small FIFO and presents {instruction, PC, valid} to the decode stage, whose opcode/func3/func7 fields come straight from `IF_INSTR`. It supports decode back-pressure (`ID_STALL`) and pipeline redirect from execute (branch/jump target), with discard of in-flight responses.

---
 rtl/otter_fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_otter_fetch_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_fetch_stage.sv
// OTTER instruction fetch stage: PC ownership, in-order IMEM requests, response FIFO to decode.
// Optional feature macro: OTTER_FETCH_MISALIGN_TRAP_EN (trap misaligned redirect targets in HALT).
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_BOOT  | single cycle after reset release, no requests
//   ST_FETCH | normal fetching and delivery to decode
//   ST_HALT  | misaligned redirect trapped, waits for aligned redirect (macro only)
module otter_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    input  logic        ID_STALL,
    output logic        IF_VALID,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_PC,
    output logic        IF_MISALIGN
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   C_ONE   = CW'(1);
    localparam logic [PW-1:0]   P_ONE   = PW'(1);
    localparam logic [CW:0]     C_DEPTH = (CW + 1)'(DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
        , ST_HALT = 2'd2
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   mem_pc_q [DEPTH];
    logic [31:0]   mem_pc_d [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_instr_d [DEPTH];

    logic          resp, push, drop, pop, issue;
    logic [CW-1:0] count_left;
    logic [CW:0]   occ;
    logic [PW-1:0] wr_idx;
    logic [31:0]   redirect_tgt;

`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
    logic redirect_mis;
    assign redirect_tgt = REDIRECT_PC;
    assign redirect_mis = |REDIRECT_PC[1:0];
`else
    assign redirect_tgt = {REDIRECT_PC[31:2], 2'b00};
`endif

    assign resp       = IMEM_RVALID && (inflight_q != '0);
    assign push       = resp && (discard_q == '0);
    assign drop       = resp && (discard_q != '0);
    assign pop        = (count_q != '0) && !ID_STALL;
    assign wr_idx     = rd_ptr_q + PW'(count_q);
    // Occupancy counts the slot freed by this cycle's pop so a full-rate stream never bubbles.
    assign count_left = count_q - (pop ? C_ONE : '0);
    assign occ        = {1'b0, inflight_q} + {1'b0, count_left};

    assign IMEM_REQ   = (state_q == ST_FETCH) && (occ < C_DEPTH) && !REDIRECT;
    assign IMEM_ADDR  = fetch_pc_q;
    assign issue      = IMEM_REQ && IMEM_GNT;

    assign IF_VALID   = (count_q != '0);
    assign IF_INSTR   = mem_instr_q[rd_ptr_q];
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
    assign IF_PC       = (state_q == ST_HALT) ? resp_pc_q : mem_pc_q[rd_ptr_q];
    assign IF_MISALIGN = (state_q == ST_HALT);
`else
    assign IF_PC       = mem_pc_q[rd_ptr_q];
    assign IF_MISALIGN = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (state_q == ST_BOOT) begin
            state_d = ST_FETCH;
        end
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
        if (REDIRECT) begin
            state_d = redirect_mis ? ST_HALT : ST_FETCH;
        end
`endif
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        rd_ptr_d    = rd_ptr_q;
        mem_pc_d    = mem_pc_q;
        mem_instr_d = mem_instr_q;
        inflight_d  = inflight_q + (issue ? C_ONE : '0) - (resp ? C_ONE : '0);
        discard_d   = discard_q - (drop ? C_ONE : '0);
        count_d     = count_q + (push ? C_ONE : '0) - (pop ? C_ONE : '0);
        if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push) begin
            mem_pc_d[wr_idx]    = resp_pc_q;
            mem_instr_d[wr_idx] = IMEM_RDATA;
            resp_pc_d           = resp_pc_q + 32'd4;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + P_ONE;
        end
        // Everything still outstanding after this cycle belongs to the old stream.
        if (REDIRECT) begin
            count_d    = '0;
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            discard_d  = inflight_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]    <= RESET_PC;
                mem_instr_q[i] <= NOP;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            resp_pc_q   <= resp_pc_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_pc_q    <= mem_pc_d;
            mem_instr_q <= mem_instr_d;
        end
    end

endmodule

// File: tb/tb_otter_fetch_stage.sv
// Bench for otter_fetch_stage: randomized in-order memory plus a stream-level model of the
// instruction sequence decode must see (PC runs from each redirect target in steps of 4).
module tb_otter_fetch_stage;

    localparam int DEPTH = 2;
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT = 1'b0;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = 32'h0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = 32'h0;
    logic        ID_STALL = 1'b0;
    logic        IF_VALID;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_PC;
    logic        IF_MISALIGN;

    otter_fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_GNT(IMEM_GNT),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .ID_STALL(ID_STALL),
        .IF_VALID(IF_VALID), .IF_INSTR(IF_INSTR), .IF_PC(IF_PC), .IF_MISALIGN(IF_MISALIGN)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_acc = 0;
    int gnt_pct = 100;
    int lat_min = 1;
    int lat_max = 1;
    int last_ready = 0;

    logic [31:0] q_addr [$];
    int          q_ready [$];

    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_fetch = 32'h0;
    logic [31:0] halt_pc = 32'h0;
    bit          halted = 1'b0;

    bit          prev_valid = 1'b0, prev_stall = 1'b0, prev_redir = 1'b0;
    logic [31:0] prev_pc = 32'h0, prev_instr = 32'h0;

    bit          obs_req, obs_valid, obs_mis, obs_acc;
    logic [31:0] obs_addr, obs_pc, obs_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return a ^ 32'h6B8B_4567;
    endfunction

    function automatic logic [31:0] align_tgt(input logic [31:0] t);
        return MIS_EN ? t : {t[31:2], 2'b00};
    endfunction

    function automatic bit rv_due();
        return (q_addr.size() != 0) && (q_ready[0] <= cyc);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_req"}, IMEM_REQ, 0);
        check({pfx, "_addr"}, IMEM_ADDR, 32'h0);
        check({pfx, "_valid"}, IF_VALID, 0);
        check({pfx, "_instr"}, IF_INSTR, NOP);
        check({pfx, "_pc"}, IF_PC, 32'h0);
        check({pfx, "_misalign"}, IF_MISALIGN, 0);
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, update the model.
    task automatic step(input bit redir, input logic [31:0] tgt, input bit stall);
        bit rv, g;
        logic [31:0] ra;
        int rdy;
        @(negedge CLK);
        RST = 1'b0;
        rv = rv_due();
        ra = rv ? q_addr[0] : 32'h0;
        g  = ($urandom_range(99) < gnt_pct);
        IMEM_GNT    = g;
        IMEM_RVALID = rv;
        IMEM_RDATA  = rv ? mem_word(ra) : $urandom;
        REDIRECT    = redir;
        REDIRECT_PC = tgt;
        ID_STALL    = stall;
        #1;
        obs_req = IMEM_REQ;  obs_addr = IMEM_ADDR;  obs_valid = IF_VALID;
        obs_pc  = IF_PC;     obs_instr = IF_INSTR;  obs_mis = IF_MISALIGN;
        obs_acc = IF_VALID && !stall;

        if (redir) check("req_in_redirect", IMEM_REQ, 0);
        if (halted) begin
            check("halt_misalign", IF_MISALIGN, 1);
            check("halt_req", IMEM_REQ, 0);
            check("halt_valid", IF_VALID, 0);
            check("halt_pc", IF_PC, halt_pc);
        end else begin
            check("misalign_clear", IF_MISALIGN, 0);
        end
        if (prev_valid && prev_stall && !prev_redir) begin
            check("stall_hold_valid", IF_VALID, 1);
            check("stall_hold_pc", IF_PC, prev_pc);
            check("stall_hold_instr", IF_INSTR, prev_instr);
        end
        if (IMEM_REQ) check("fetch_addr", IMEM_ADDR, exp_fetch);
        if (obs_acc) begin
            check("stream_pc", IF_PC, exp_pc);
            check("stream_instr", IF_INSTR, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_acc++;
        end

        if (rv) begin
            void'(q_addr.pop_front());
            void'(q_ready.pop_front());
        end
        if (IMEM_REQ && g) begin
            rdy = cyc + $urandom_range(lat_max, lat_min);
            if (rdy <= last_ready) rdy = last_ready + 1;
            q_addr.push_back(IMEM_ADDR);
            q_ready.push_back(rdy);
            last_ready = rdy;
            exp_fetch = exp_fetch + 32'd4;
        end
        check("outstanding_le_depth", (q_addr.size() <= DEPTH), 1);

        if (redir) begin
            exp_pc    = align_tgt(tgt);
            exp_fetch = align_tgt(tgt);
            halted    = MIS_EN && (tgt[1:0] != 2'b00);
            halt_pc   = tgt;
        end
        prev_valid = IF_VALID;
        prev_stall = stall;
        prev_redir = redir;
        prev_pc    = IF_PC;
        prev_instr = IF_INSTR;
        cyc++;
    endtask

    task automatic wait_acc(input string tag, input int budget);
        bit found;
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            step(1'b0, 32'h0, 1'b0);
            found = obs_acc;
        end
        check({tag, "_timeout"}, found, 1);
    endtask

    initial begin
        int acc0;
        bit hit;
        logic [31:0] t;

        repeat (3) @(negedge CLK);
        #1;
        check_reset_vals("reset");

        // Reset release with zero-wait memory
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        step(0, 32'h0, 0);
        check("boot_req", obs_req, 0);
        step(0, 32'h0, 0);
        check("first_req", obs_req, 1);
        check("first_addr", obs_addr, 32'h0);
        step(0, 32'h0, 0);
        check("first_valid_early", obs_valid, 0);
        step(0, 32'h0, 0);
        check("first_valid", obs_valid, 1);
        check("first_pc", obs_pc, 32'h0);
        check("first_instr", obs_instr, 32'h0050_0093);
        step(0, 32'h0, 0);
        check("second_pc", obs_pc, 32'h4);
        step(0, 32'h0, 0);
        check("third_pc", obs_pc, 32'h8);

        // Decode stall for 5 cycles, then full-rate resume
        repeat (5) step(0, 32'h0, 1);
        check("stall_full_req", obs_req, 0);
        check("stall_full_valid", obs_valid, 1);
        acc0 = n_acc;
        repeat (10) step(0, 32'h0, 0);
        check("throughput_after_stall", n_acc - acc0, 10);

        // Slow memory, two stale in flight, redirect to 0x100
        lat_min = 3; lat_max = 3;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step(0, 32'h0, 0);
            hit = (q_addr.size() == 2);
        end
        check("two_inflight_reached", hit, 1);
        step(1, 32'h100, 0);
        wait_acc("redir100", 30);
        check("redir100_pc", obs_pc, 32'h100);
        check("redir100_instr", obs_instr, mem_word(32'h100));

        // Redirect coincident with a response and a grant
        lat_min = 2; lat_max = 2;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (rv_due()) begin
                step(1, 32'h300, 0);
                hit = 1'b1;
            end else begin
                step(0, 32'h0, 0);
            end
        end
        check("redir_on_rvalid_hit", hit, 1);
        wait_acc("redir300", 30);
        check("redir300_pc", obs_pc, 32'h300);
        check("redir300_instr", obs_instr, mem_word(32'h300));
        lat_min = 1; lat_max = 1;
        repeat (8) step(0, 32'h0, 0);
        acc0 = n_acc;
        repeat (10) step(0, 32'h0, 0);
        check("throughput_after_redirect", n_acc - acc0, 10);

        // Misaligned redirect target
        step(1, 32'h102, 0);
`ifdef OTTER_FETCH_MISALIGN_TRAP_EN
        repeat (8) step(0, 32'h0, 0);
        check("mis_flag", obs_mis, 1);
        check("mis_req", obs_req, 0);
        step(1, 32'h200, 0);
        wait_acc("mis_resume", 30);
        check("mis_resume_pc", obs_pc, 32'h200);
        check("mis_resume_flag", obs_mis, 0);
`else
        wait_acc("mis_ignored", 30);
        check("mis_ignored_pc", obs_pc, 32'h100);
        check("mis_ignored_flag", obs_mis, 0);
`endif

        // PC wrap at the top of the address space
        repeat (8) step(0, 32'h0, 0);
        step(1, 32'hFFFF_FFFC, 0);
        step(0, 32'h0, 0);
        check("wrap_req", obs_req, 1);
        check("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
        step(0, 32'h0, 0);
        check("wrap_addr1", obs_addr, 32'h0);
        step(0, 32'h0, 0);
        check("wrap_pc0_valid", obs_acc, 1);
        check("wrap_pc0", obs_pc, 32'hFFFF_FFFC);
        step(0, 32'h0, 0);
        check("wrap_pc1", obs_pc, 32'h0);
        check("wrap_instr1", obs_instr, 32'h0050_0093);

        // Randomized traffic
        gnt_pct = 75; lat_min = 1; lat_max = 4;
        acc0 = n_acc;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(99) < 3) begin
                t = $urandom;
                if (MIS_EN && $urandom_range(3) != 0) t[1:0] = 2'b00;
                step(1, t, ($urandom_range(99) < 25));
            end else begin
                step(0, 32'h0, ($urandom_range(99) < 25));
            end
        end
        check("random_progress", (n_acc - acc0 > 100), 1);

        // Asynchronous reset in the middle of activity
        step(1, 32'h40, 0);
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        repeat (6) step(0, 32'h0, 0);
        #2;
        RST = 1'b1;
        #1;
        check_reset_vals("async_reset");
        REDIRECT = 1'b0; IMEM_RVALID = 1'b0; IMEM_GNT = 1'b0; ID_STALL = 1'b0;
        q_addr.delete();
        q_ready.delete();
        last_ready = cyc;
        exp_pc = 32'h0; exp_fetch = 32'h0; halted = 1'b0;
        prev_valid = 1'b0; prev_redir = 1'b0;
        repeat (2) @(negedge CLK);
        step(0, 32'h0, 0);
        check("rerun_boot_req", obs_req, 0);
        step(0, 32'h0, 0);
        check("rerun_req", obs_req, 1);
        check("rerun_addr", obs_addr, 32'h0);
        wait_acc("rerun", 10);
        check("rerun_pc", obs_pc, 32'h0);
        repeat (10) step(0, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
